impulse_response_capture: RTL and testbench

- Sits directly downstream of the impulse generator.
- Triggered by the generator's single-cycle impulse flag; records the next DEPTH mic samples (one per audio step) into an internal buffer.
- Tracks the peak absolute amplitude and its sample index, which gives the acoustic round-trip latency in audio steps.
- The host/analysis logic then reads the buffer back through a simple synchronous read port.

---
 rtl/impulse_response_capture.sv | 133 +++++++++++++
 tb/tb_impulse_response_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/impulse_response_capture.sv
// Records DEPTH mic samples after an impulse trigger, tracks the first peak |sample|
// and its index, and exposes the buffer through a 1-cycle-latency read port.
module impulse_response_capture #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     step_in,
   input  logic                     impulse_in,
   input  logic signed [15:0]       mic_in,
   input  logic                     rd_en_in,
   input  logic [ADDR_W-1:0]        rd_addr_in,
   output logic signed [15:0]       rd_data_out,
   output logic                     rd_valid_out,
   output logic                     busy_out,
   output logic                     done_out,
   output logic                     capture_valid_out,
   output logic [15:0]              peak_amp_out,
   output logic [ADDR_W-1:0]        peak_index_out
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_W-1:0]     count_reg;
   logic [15:0]           peak_amp_reg;
   logic [ADDR_W-1:0]     peak_index_reg;
   logic                  done_reg;
   logic                  valid_reg;
   logic                  rd_valid_reg;
   logic signed [15:0]    rd_data_reg;
   logic signed [15:0]    mem [DEPTH];

   logic [15:0]           abs_sample;
   logic                  trigger;
   logic                  write_en;
   logic                  last_write;
   logic                  read_ok;

   // Magnitude with -32768 clamped so the peak always fits in 15 bits.
   always_comb begin
      abs_sample = mic_in;
      if (mic_in == 16'sh8000)
         abs_sample = 16'h7FFF;
      else if (mic_in[15])
         abs_sample = 16'(~mic_in) + 16'd1;
   end

   assign trigger    = impulse_in && (state_reg != CAPTURE);
   assign write_en   = step_in && (state_reg == CAPTURE);
   assign last_write = write_en && (count_reg == ADDR_W'(DEPTH - 1));
   assign read_ok    = rd_en_in && (state_reg != CAPTURE);

   always_ff @(posedge clk_in) begin
      if (rst_in)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy_out   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (impulse_in)
               state_next = CAPTURE;
         end
         CAPTURE: begin
            busy_out = 1'b1;
            if (last_write)
               state_next = DONE;
         end
         DONE: begin
            if (impulse_in)
               state_next = CAPTURE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_reg      <= '0;
         peak_amp_reg   <= '0;
         peak_index_reg <= '0;
         done_reg       <= 1'b0;
         valid_reg      <= 1'b0;
      end else begin
         done_reg <= last_write;
         if (trigger) begin
            count_reg      <= '0;
            peak_amp_reg   <= '0;
            peak_index_reg <= '0;
            valid_reg      <= 1'b0;
         end else if (write_en) begin
            count_reg <= count_reg + 1'b1;
            // Strict compare keeps the earliest sample of a tie.
            if (abs_sample > peak_amp_reg) begin
               peak_amp_reg   <= abs_sample;
               peak_index_reg <= count_reg;
            end
            if (last_write)
               valid_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (write_en)
         mem[count_reg] <= mic_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= read_ok;
         if (read_ok)
            rd_data_reg <= mem[rd_addr_in];
      end
   end

   assign rd_data_out       = rd_data_reg;
   assign rd_valid_out      = rd_valid_reg;
   assign done_out          = done_reg;
   assign capture_valid_out = valid_reg;
   assign peak_amp_out      = peak_amp_reg;
   assign peak_index_out    = peak_index_reg;

endmodule

// File: tb/tb_impulse_response_capture.sv
// Bench for impulse_response_capture: directed scenarios plus randomized captures,
// checked against an array/loop reference model of the capture rules.
module tb_impulse_response_capture;

   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 step = 1'b0;
   logic                 impulse = 1'b0;
   logic signed [15:0]   mic = '0;
   logic                 rd_en = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic signed [15:0]   rd_data;
   logic                 rd_valid;
   logic                 busy;
   logic                 done;
   logic                 cap_valid;
   logic [15:0]          peak_amp;
   logic [AW-1:0]        peak_index;

   int total = 0;
   int bad   = 0;

   logic signed [15:0] samp      [DEPTH];
   logic signed [15:0] mem_model [DEPTH];
   logic signed [15:0] last_rd;

   impulse_response_capture #(.DEPTH(DEPTH)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .step_in           (step),
      .impulse_in        (impulse),
      .mic_in            (mic),
      .rd_en_in          (rd_en),
      .rd_addr_in        (rd_addr),
      .rd_data_out       (rd_data),
      .rd_valid_out      (rd_valid),
      .busy_out          (busy),
      .done_out          (done),
      .capture_valid_out (cap_valid),
      .peak_amp_out      (peak_amp),
      .peak_index_out    (peak_index)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Earliest sample with the largest saturated magnitude.
   task automatic expected_peak(output int amp, output int idx);
      amp = 0;
      idx = 0;
      for (int i = 0; i < DEPTH; i++) begin
         int v;
         v = samp[i];
         if (v < 0) v = -v;
         if (v > 32767) v = 32767;
         if (v > amp) begin
            amp = v;
            idx = i;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      last_rd = '0;
      check_value("rst_busy", 32'(busy), 0);
      check_value("rst_done", 32'(done), 0);
      check_value("rst_valid", 32'(cap_valid), 0);
      check_value("rst_peak", 32'(peak_amp), 0);
      check_value("rst_pidx", 32'(peak_index), 0);
      check_value("rst_rdv", 32'(rd_valid), 0);
      check_value("rst_rdd", 32'(rd_data), 0);
   endtask

   // trig_step: step coincides with trigger (mic=999, must not be stored).
   // mid_imp: index before whose step a stray impulse is sent (-1 none).
   // abort_at: index before whose step reset is asserted (-1 none).
   // probe: issue reads during capture gaps, which must be ignored.
   task automatic run_capture(input bit trig_step, input int mid_imp, input int abort_at, input bit probe);
      int amp, idx;
      impulse = 1'b1;
      if (trig_step) begin
         step = 1'b1;
         mic  = 16'sd999;
      end
      tick();
      impulse = 1'b0;
      step    = 1'b0;
      mic     = '0;
      check_value("arm_busy", 32'(busy), 1);
      check_value("arm_valid", 32'(cap_valid), 0);
      check_value("arm_peak", 32'(peak_amp), 0);
      check_value("arm_pidx", 32'(peak_index), 0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            last_rd = '0;
            check_value("abort_busy", 32'(busy), 0);
            check_value("abort_valid", 32'(cap_valid), 0);
            check_value("abort_done", 32'(done), 0);
            check_value("abort_peak", 32'(peak_amp), 0);
            tick();
            check_value("abort_done2", 32'(done), 0);
            $display("capture aborted after %0d samples", i);
            return;
         end
         repeat ($urandom_range(1, 3)) begin
            if (i == mid_imp) impulse = 1'b1;
            if (probe) begin
               rd_en   = 1'b1;
               rd_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            tick();
            impulse = 1'b0;
            rd_en   = 1'b0;
            if (probe) begin
               check_value("cap_rdv", 32'(rd_valid), 0);
               check_value("cap_rdd", 32'(rd_data), 32'(last_rd));
            end
            check_value("cap_busy", 32'(busy), 1);
         end
         step = 1'b1;
         mic  = samp[i];
         tick();
         step = 1'b0;
         mem_model[i] = samp[i];
         check_value("step_done", 32'(done), (i == DEPTH - 1) ? 1 : 0);
      end
      expected_peak(amp, idx);
      check_value("end_valid", 32'(cap_valid), 1);
      check_value("end_busy", 32'(busy), 0);
      check_value("end_peak", 32'(peak_amp), 32'(amp));
      check_value("end_pidx", 32'(peak_index), 32'(idx));
      tick();
      check_value("end_done1", 32'(done), 0);
      check_value("end_valid1", 32'(cap_valid), 1);
      $display("capture done: peak=%0d index=%0d", peak_amp, peak_index);
   endtask

   // Back-to-back reads of the whole buffer.
   task automatic read_all();
      rd_en   = 1'b1;
      rd_addr = '0;
      tick();
      for (int a = 0; a < DEPTH; a++) begin
         if (a == DEPTH - 1) rd_en = 1'b0;
         else rd_addr = AW'(a + 1);
         check_value("rdall_v", 32'(rd_valid), 1);
         check_value("rdall_d", 32'(rd_data), 32'(mem_model[a]));
         last_rd = mem_model[a];
         tick();
      end
      check_value("rdall_end", 32'(rd_valid), 0);
      $display("buffer readback of %0d words", DEPTH);
   endtask

   task automatic read_random(input int n);
      for (int k = 0; k < n; k++) begin
         int a;
         a = $urandom_range(0, DEPTH - 1);
         rd_en   = 1'b1;
         rd_addr = AW'(a);
         tick();
         rd_en = 1'b0;
         check_value("rdr_v", 32'(rd_valid), 1);
         check_value("rdr_d", 32'(rd_data), 32'(mem_model[a]));
         last_rd = mem_model[a];
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   function automatic logic signed [15:0] rand_sample();
      case ($urandom_range(0, 5))
         0: return 16'sh8000;
         1: return 16'sh7FFF;
         2: return 16'sh8001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic signed [15:0] t1 [DEPTH];
      logic signed [15:0] t2 [DEPTH];
      t1 = '{16'sd10, -16'sd20, 16'sd30, -16'sd40, 16'sd50, -16'sd60, 16'sd70, -16'sd5};
      t2 = '{16'sd0, 16'sd100, -16'sd100, -16'sd32768, -16'sd32768, 16'sd0, 16'sd0, 16'sd0};
      for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
      last_rd = '0;
      do_reset();

      samp = t1;
      run_capture(1'b0, -1, -1, 1'b0);
      check_value("t1_peak", 32'(peak_amp), 70);
      check_value("t1_pidx", 32'(peak_index), 6);
      read_all();

      samp = t2;
      run_capture(1'b1, 3, -1, 1'b1);
      check_value("t2_peak", 32'(peak_amp), 32767);
      check_value("t2_pidx", 32'(peak_index), 3);
      read_all();

      for (int i = 0; i < DEPTH; i++) samp[i] = rand_sample();
      run_capture(1'b0, -1, 4, 1'b0);
      for (int i = 0; i < DEPTH; i++) samp[i] = rand_sample();
      run_capture(1'b0, -1, -1, 1'b0);
      read_all();

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) samp[i] = rand_sample();
         run_capture(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH)), -1,
                     1'($urandom_range(0, 1)));
         read_random(6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
